risc_processor: RTL and testbench

// - Single-cycle 32-bit RISC core with built-in instruction ROM and register file; top-level compute block.
// - Executes one instruction per clock from a fixed program after reset.
// - Exposes the last ALU write-back value on `result` for observation.

---
 rtl/risc_processor.sv | 134 +++++++++++++
 tb/tb_risc_processor.sv | 82 ++++++++
 2 files changed

// File: rtl/risc_processor.sv
// rtl/risc_processor.sv - single-cycle 32-bit RISC core with built-in program ROM and register file
// PROGRAM selects the ROM image: 0 = reference program, 1..2 = alternate images for variant builds.
module risc_processor #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int NREG       = 8,
  parameter int PROGRAM    = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] result
);
  localparam int PC_W = $clog2(IMEM_DEPTH);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, 3'b000, imm};
  endfunction

  logic [PC_W-1:0]   pc;
  logic              halted;
  logic [DATA_W-1:0] regs [NREG];
  logic [31:0]       instr;

  // Unlisted ROM entries decode as HALT
  always_comb begin
    instr = {OP_HALT, 28'h0};
    if (PROGRAM == 1) begin
      case (int'(pc))
        0: instr = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 16'hFFFF);
        1: instr = enc(OP_ADDI, 3'd2, 3'd1, 3'd0, 16'd1);
        2: instr = enc(OP_ADDI, 3'd0, 3'd0, 3'd0, 16'd7);
        3: instr = enc(OP_ADD,  3'd1, 3'd0, 3'd0, 16'd0);
        default: ;
      endcase
    end else if (PROGRAM == 2) begin
      case (int'(pc))
        0:  instr = enc(OP_ADDI, 3'd1, 3'd1, 3'd0, 16'd1);
        1:  instr = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 16'd1);
        2:  instr = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 16'd9);
        3:  instr = enc(OP_JMP,  3'd0, 3'd0, 3'd0, 16'd14);
        14: instr = enc(OP_ADDI, 3'd2, 3'd1, 3'd0, 16'd16);
        15: instr = 32'h0;
        default: ;
      endcase
    end else begin
      case (int'(pc))
        0: instr = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 16'd5);
        1: instr = enc(OP_ADDI, 3'd2, 3'd0, 3'd0, 16'd3);
        2: instr = enc(OP_ADD,  3'd3, 3'd1, 3'd2, 16'd0);
        3: instr = enc(OP_SUB,  3'd4, 3'd1, 3'd2, 16'd0);
        4: instr = enc(OP_AND,  3'd5, 3'd1, 3'd2, 16'd0);
        5: instr = enc(OP_OR,   3'd6, 3'd1, 3'd2, 16'd0);
        6: instr = enc(OP_XOR,  3'd7, 3'd1, 3'd2, 16'd0);
        default: ;
      endcase
    end
  end

  logic [3:0]        op;
  logic [2:0]        rd, rs1, rs2;
  logic [15:0]       imm;
  logic [DATA_W-1:0] a, b, imm_ext, wr_val;
  logic              wr_en;
  logic [PC_W-1:0]   pc_next;
  logic              unused_bits;

  assign op          = instr[31:28];
  assign rd          = instr[27:25];
  assign rs1         = instr[24:22];
  assign rs2         = instr[21:19];
  assign imm         = instr[15:0];
  assign unused_bits = ^instr[18:16];
  assign imm_ext     = {{(DATA_W-16){imm[15]}}, imm};
  assign a           = (rs1 == 3'd0) ? '0 : regs[rs1];
  assign b           = (rs2 == 3'd0) ? '0 : regs[rs2];

  always_comb begin
    wr_en   = 1'b1;
    wr_val  = '0;
    pc_next = pc + PC_W'(1);
    case (op)
      OP_ADD:  wr_val = a + b;
      OP_SUB:  wr_val = a - b;
      OP_AND:  wr_val = a & b;
      OP_OR:   wr_val = a | b;
      OP_XOR:  wr_val = a ^ b;
      OP_SLL:  wr_val = a << b[4:0];
      OP_SRL:  wr_val = a >> b[4:0];
      OP_ADDI: wr_val = a + imm_ext;
      OP_BEQ: begin
        wr_en = 1'b0;
        if (a == b) pc_next = pc + PC_W'(1) + imm[PC_W-1:0];
      end
      OP_JMP: begin
        wr_en   = 1'b0;
        pc_next = imm[PC_W-1:0];
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      halted <= 1'b0;
      result <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (!halted) begin
      if (op == OP_HALT) begin
        halted <= 1'b1;
      end else begin
        pc <= pc_next;
        if (wr_en) begin
          result <= wr_val;
          if (rd != 3'd0) regs[rd] <= wr_val;
        end
      end
    end
  end
endmodule

// File: tb/tb_risc_processor.sv
// tb/tb_risc_processor.sv - scoreboard bench for risc_processor across three ROM images
// Stimulus pushes per-edge expected results; a monitor pops and compares at each falling edge.
module tb_risc_processor;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] res0, res1, res2;

  always #5 clk = ~clk;

  risc_processor #(.PROGRAM(0)) u_p0 (.clk(clk), .reset(reset), .result(res0));
  risc_processor #(.PROGRAM(1)) u_p1 (.clk(clk), .reset(reset), .result(res1));
  risc_processor #(.PROGRAM(2)) u_p2 (.clk(clk), .reset(reset), .result(res2));

  typedef struct {
    int          tag;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  event probe;

  logic [31:0] tab0 [22] = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6,
                             32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6};
  logic [31:0] tab1 [22] = '{32'hFFFF_FFFF, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                             32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] tab2 [22] = '{32'd1, 32'd1, 32'd1, 32'd17, 32'd17, 32'd2, 32'd2, 32'd2, 32'd18, 32'd18, 32'd3,
                             32'd3, 32'd3, 32'd19, 32'd19, 32'd4, 32'd4, 32'd4, 32'd20, 32'd20, 32'd5, 32'd5};

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", name, tag, act, exp);
    end
  endtask

  always begin
    exp_t x;
    @(negedge clk or probe);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      check("prog0_result", x.tag, res0, x.e0);
      check("prog1_result", x.tag, res1, x.e1);
      check("prog2_result", x.tag, res2, x.e2);
    end
  end

  task automatic step(input int tag, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    @(posedge clk);
    #1;
    sb.push_back('{tag, e0, e1, e2});
  endtask

  initial begin
    step(0, 32'd0, 32'd0, 32'd0);
    #6 reset = 1'b1;
    for (int k = 0; k < 3; k++) step(100 + k + 1, tab0[k], tab1[k], tab2[k]);

    // Short reset pulse between edges: cleared immediately, then restarts from PC 0
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    sb.push_back('{200, 32'd0, 32'd0, 32'd0});
    ->probe;
    #1 reset = 1'b1;

    for (int k = 0; k < 22; k++) step(300 + k + 1, tab0[k], tab1[k], tab2[k]);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
